// File: rtl/pic_bus_master.sv
// Host-side bus master for the 8259A-style interrupt controller core.
// Runs the ICW init sequence, single OCW writes / status reads, and the two-pulse INTA vector fetch.
module pic_bus_master #(
    parameter logic [7:0] ICW1_VAL     = 8'h13,
    parameter logic [7:0] ICW2_VAL     = 8'h08,
    parameter logic [7:0] ICW3_VAL     = 8'h00,
    parameter logic [7:0] ICW4_VAL     = 8'h01,
    parameter int         PULSE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_init,
    output logic       init_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       int_in,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       inta_n,
    output logic       a0,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in,
    output logic       busy
);

    localparam int CW = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(1);
    localparam bit SEND_ICW3 = !ICW1_VAL[1];
    localparam bit SEND_ICW4 = ICW1_VAL[0];

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, IGAP} state_t;
    typedef enum logic [1:0] {K_WR, K_RD, K_INTA} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inta2_q, inta2_d;
    logic          init_act_q, init_act_d;
    logic [1:0]    idx_q, idx_d;
    logic          done_q, done_d;
    logic          a0_q, a0_d;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    vec_data_q, vec_data_d;
    logic          vec_valid_q, vec_valid_d;
    logic          sync1_q, sync2_q;
    logic          intack_pending;
    logic [2:0]    nxt_idx;
    logic          in_cycle;

    // Index 4 means the ICW list is exhausted; ICW3/ICW4 are skipped per ICW1 flags.
    function automatic logic [2:0] next_index(input logic [1:0] idx);
        logic [2:0] n;
        n = 3'd4;
        case (idx)
            2'd0:    n = 3'd1;
            2'd1:    n = SEND_ICW3 ? 3'd2 : (SEND_ICW4 ? 3'd3 : 3'd4);
            2'd2:    n = SEND_ICW4 ? 3'd3 : 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] icw_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = ICW1_VAL;
            2'd1:    b = ICW2_VAL;
            2'd2:    b = ICW3_VAL;
            default: b = ICW4_VAL;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= int_in;
            sync2_q <= sync1_q;
        end
    end

    assign intack_pending = sync2_q & done_q;
    assign cmd_ready      = (state_q == IDLE) & done_q & ~intack_pending;
    assign nxt_idx        = next_index(idx_q);

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        inta2_d     = inta2_q;
        init_act_d  = init_act_q;
        idx_d       = idx_q;
        done_d      = done_q;
        a0_d        = a0_q;
        dout_d      = dout_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        vec_data_d  = vec_data_q;
        vec_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (intack_pending) begin
                    state_d = SETUP;
                    kind_d  = K_INTA;
                    inta2_d = 1'b0;
                end else if (init_act_q) begin
                    state_d = SETUP;
                    kind_d  = K_WR;
                    a0_d    = (idx_q != 2'd0);
                    dout_d  = icw_byte(idx_q);
                end else if (cmd_valid && cmd_ready) begin
                    state_d = SETUP;
                    kind_d  = cmd_rd ? K_RD : K_WR;
                    a0_d    = cmd_a0;
                    if (!cmd_rd) dout_d = cmd_data;
                end else if (start_init) begin
                    state_d    = SETUP;
                    kind_d     = K_WR;
                    done_d     = 1'b0;
                    init_act_d = 1'b1;
                    idx_d      = 2'd0;
                    a0_d       = 1'b0;
                    dout_d     = ICW1_VAL;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = PULSE_LOAD;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (kind_q == K_INTA && !inta2_q) begin
                        state_d = IGAP;
                        cnt_d   = GAP_LOAD;
                        inta2_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                        if (kind_q == K_RD) begin
                            rsp_data_d  = d_in;
                            rsp_valid_d = 1'b1;
                        end
                        if (kind_q == K_INTA) begin
                            vec_data_d  = d_in;
                            vec_valid_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IGAP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                if (init_act_q) begin
                    if (nxt_idx[2]) begin
                        done_d     = 1'b1;
                        init_act_d = 1'b0;
                    end else begin
                        idx_d = nxt_idx[1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            kind_q      <= K_WR;
            cnt_q       <= '0;
            inta2_q     <= 1'b0;
            init_act_q  <= 1'b0;
            idx_q       <= 2'd0;
            done_q      <= 1'b0;
            a0_q        <= 1'b0;
            dout_q      <= 8'h00;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            vec_data_q  <= 8'h00;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            inta2_q     <= inta2_d;
            init_act_q  <= init_act_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            a0_q        <= a0_d;
            dout_q      <= dout_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            vec_data_q  <= vec_data_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    // Strobes decode straight from state so an async reset releases them instantly.
    assign in_cycle  = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign cs_n      = ~(in_cycle && kind_q != K_INTA);
    assign wr_n      = ~(state_q == STROBE && kind_q == K_WR);
    assign rd_n      = ~(state_q == STROBE && kind_q == K_RD);
    assign inta_n    = ~(state_q == STROBE && kind_q == K_INTA);
    assign d_oe      = in_cycle && kind_q == K_WR;
    assign a0        = a0_q;
    assign d_out     = dout_q;
    assign busy      = (state_q != IDLE);
    assign init_done = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;

endmodule

// File: tb/tb_pic_bus_master.sv
// Randomised self-checking bench for pic_bus_master: a cycle-timeline model of the expected
// bus activity is built from the transaction rules and compared against the pins every cycle.
module tb_pic_bus_master;
    localparam int P   = 2;
    localparam int P11 = 1;
    localparam logic [7:0] ICW1 = 8'h13, ICW2 = 8'h08, ICW3 = 8'h00, ICW4 = 8'h01;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start_init, cmd_valid, cmd_rd, cmd_a0, int_in;
    logic [7:0] cmd_data, d_in;
    logic       init_done, cmd_ready, rsp_valid, vec_valid, cs_n, rd_n, wr_n, inta_n, a0, d_oe, busy;
    logic [7:0] rsp_data, vec_data, d_out;

    logic       start11;
    logic       done11, rdy11, rspv11, vecv11, cs11, rd11, wr11, inta11, a011, oe11, busy11;
    logic [7:0] rspd11, vecd11, dout11;

    pic_bus_master #(.ICW1_VAL(ICW1), .ICW2_VAL(ICW2), .ICW3_VAL(ICW3), .ICW4_VAL(ICW4),
                     .PULSE_CYCLES(P)) dut (
        .clk(clk), .reset_n(reset_n), .start_init(start_init), .init_done(init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_a0(cmd_a0),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .int_in(int_in),
        .vec_valid(vec_valid), .vec_data(vec_data), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .inta_n(inta_n), .a0(a0), .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .busy(busy));

    pic_bus_master #(.ICW1_VAL(8'h11), .PULSE_CYCLES(P11)) dut11 (
        .clk(clk), .reset_n(reset_n), .start_init(start11), .init_done(done11),
        .cmd_valid(1'b0), .cmd_ready(rdy11), .cmd_rd(1'b0), .cmd_a0(1'b0),
        .cmd_data(8'h00), .rsp_valid(rspv11), .rsp_data(rspd11), .int_in(1'b0),
        .vec_valid(vecv11), .vec_data(vecd11), .cs_n(cs11), .rd_n(rd11), .wr_n(wr11),
        .inta_n(inta11), .a0(a011), .d_out(dout11), .d_oe(oe11), .d_in(8'h00), .busy(busy11));

    typedef struct packed {
        logic busy, cs_n, rd_n, wr_n, inta_n, d_oe, a0;
        logic [7:0] d_out;
        logic rsp_v, vec_v;
    } exp_t;
    localparam exp_t IDLE_REC = '{busy:1'b0, cs_n:1'b1, rd_n:1'b1, wr_n:1'b1, inta_n:1'b1,
                                  d_oe:1'b0, a0:1'b0, d_out:8'h00, rsp_v:1'b0, vec_v:1'b0};

    exp_t       exp_tl[int];
    bit         int_at[int];
    logic [7:0] din_at[int];
    int         cyc = 0, done_from = BIG, busy_until = -1;
    int         n_chk = 0, n_pass = 0;
    bit         din_force = 0;
    logic [7:0] din_val = 8'h00;
    logic [7:0] m_rsp = 8'h00, m_vec = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        d_in = din_force ? din_val : 8'($urandom);
    endtask

    task automatic idle_to();
        while (cyc <= busy_until) tick();
    endtask

    // s = SETUP cycle of a generic write/read cycle.
    task automatic sched_cyc(input int s, input bit rd, input bit a0v, input logic [7:0] d);
        exp_t e;
        for (int k = 0; k < P + 2; k++) begin
            e = IDLE_REC;
            e.busy = 1'b1; e.cs_n = 1'b0; e.a0 = a0v; e.d_oe = !rd; e.d_out = d;
            if (k >= 1 && k <= P) begin
                if (rd) e.rd_n = 1'b0; else e.wr_n = 1'b0;
            end
            if (k == P + 1 && rd) e.rsp_v = 1'b1;
            exp_tl[s + k] = e;
        end
    endtask

    task automatic sched_inta(input int s);
        exp_t e;
        for (int k = 0; k < 2 * P + 4; k++) begin
            e = IDLE_REC;
            e.busy = 1'b1;
            if ((k >= 1 && k <= P) || (k >= P + 3 && k <= 2 * P + 2)) e.inta_n = 1'b0;
            if (k == 2 * P + 3) e.vec_v = 1'b1;
            exp_tl[s + k] = e;
        end
    endtask

    task automatic do_init();
        logic [7:0] b[$];
        bit         av[$];
        int         c, s;
        c = cyc;
        b.push_back(ICW1); av.push_back(1'b0);
        b.push_back(ICW2); av.push_back(1'b1);
        if (!ICW1[1]) begin b.push_back(ICW3); av.push_back(1'b1); end
        if (ICW1[0])  begin b.push_back(ICW4); av.push_back(1'b1); end
        s = c + 1;
        foreach (b[k]) begin
            s = c + 1 + k * (P + 3);
            sched_cyc(s, 1'b0, av[k], b[k]);
        end
        busy_until = s + P + 1;
        done_from  = s + P + 2;
        start_init = 1'b1;
        tick();
        start_init = 1'b0;
    endtask

    task automatic do_cmd(input bit rd, input bit a0v, input logic [7:0] d);
        int c;
        c = cyc;
        sched_cyc(c + 1, rd, a0v, d);
        busy_until = c + P + 2;
        cmd_valid = 1'b1; cmd_rd = rd; cmd_a0 = a0v; cmd_data = d;
        tick();
        cmd_valid = 1'b0;
        idle_to();
    endtask

    task automatic do_int(input int hold);
        int t;
        t = cyc;
        sched_inta(t + 3);
        busy_until = t + 2 * P + 6;
        int_in = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        int_in = 1'b0;
        idle_to();
    endtask

    // Per-cycle comparison against the timeline model.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_done, pend;
        int_at[cyc] = int_in;
        din_at[cyc] = d_in;
        if (!reset_n) begin
            m_rsp = 8'h00;
            m_vec = 8'h00;
            check("reset_outs", {cs_n, rd_n, wr_n, inta_n, a0, d_oe, init_done, cmd_ready,
                                 rsp_valid, vec_valid, busy, d_out, rsp_data, vec_data},
                  {11'b1111_0000000, 24'h0});
        end else begin
            e = exp_tl.exists(cyc) ? exp_tl[cyc] : IDLE_REC;
            check("pins", {busy, cs_n, rd_n, wr_n, inta_n, d_oe},
                  {e.busy, e.cs_n, e.rd_n, e.wr_n, e.inta_n, e.d_oe});
            if (!e.cs_n) check("a0", a0, e.a0);
            if (e.d_oe) check("d_out", d_out, e.d_out);
            if (e.rsp_v) m_rsp = din_at[cyc - 1];
            if (e.vec_v) m_vec = din_at[cyc - 1];
            check("rsp", {rsp_valid, rsp_data}, {e.rsp_v, m_rsp});
            check("vec", {vec_valid, vec_data}, {e.vec_v, m_vec});
            exp_done = (cyc >= done_from);
            pend = int_at.exists(cyc - 2) && int_at[cyc - 2] && exp_done;
            check("init_done", init_done, exp_done);
            check("cmd_ready", cmd_ready, !e.busy && exp_done && !pend);
            check("exclusive", ({1'b0, ~rd_n} + {1'b0, ~wr_n} + {1'b0, ~inta_n}) <= 2'd1, 1);
        end
    end

    // Write-pulse monitors: captured (a0,data) and low width per pulse.
    logic [8:0] wq[$], q11[$];
    int         wwq[$], w11q[$];
    logic       wprev = 1'b1, wprev11 = 1'b1;
    int         wlen = 0, wlen11 = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            wprev = 1'b1; wlen = 0; wprev11 = 1'b1; wlen11 = 0;
        end else begin
            if (!wr_n) begin
                if (wprev) wq.push_back({a0, d_out});
                wlen++;
            end else if (!wprev) begin
                wwq.push_back(wlen); wlen = 0;
            end
            wprev = wr_n;
            if (!wr11) begin
                if (wprev11) q11.push_back({a011, dout11});
                wlen11++;
            end else if (!wprev11) begin
                w11q.push_back(wlen11); wlen11 = 0;
            end
            wprev11 = wr11;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [8:0] exp_w[3];
        logic [8:0] exp_w11[4];
        int c, t;
        exp_w   = '{{1'b0, 8'h13}, {1'b1, 8'h08}, {1'b1, 8'h01}};
        exp_w11 = '{{1'b0, 8'h11}, {1'b1, 8'h08}, {1'b1, 8'h00}, {1'b1, 8'h01}};
        reset_n = 1'b0; start_init = 1'b0; start11 = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0;
        cmd_a0 = 1'b0; cmd_data = 8'h00; int_in = 1'b0; d_in = 8'h00;
        repeat (3) tick();
        reset_n = 1'b1;
        // Commands before init must be refused (model expects cmd_ready=0, no bus cycle).
        cmd_valid = 1'b1;
        repeat (3) tick();
        cmd_valid = 1'b0;

        start11 = 1'b1;
        do_init();
        start11 = 1'b0;
        idle_to();
        for (int i = 0; i < 50 && !done11; i++) tick();
        check("dut11_init_done", done11, 1);
        check("init_nwr", wq.size(), 3);
        foreach (exp_w[i]) if (i < wq.size()) check("init_wr", wq[i], exp_w[i]);
        foreach (wwq[i]) check("init_wr_width", wwq[i], P);
        check("init11_nwr", q11.size(), 4);
        foreach (exp_w11[i]) if (i < q11.size()) check("init11_wr", q11[i], exp_w11[i]);
        foreach (w11q[i]) check("init11_wr_width", w11q[i], P11);
        wq.delete(); wwq.delete();

        din_force = 1'b1; din_val = 8'hA5;
        do_cmd(1'b1, 1'b1, 8'h00);
        check("read_A5", rsp_data, 8'hA5);
        din_val = 8'h0B;
        do_int(2);
        check("vector_0B", vec_data, 8'h0B);
        din_force = 1'b0;

        // Interrupt and write pending together: INTA first, write afterwards.
        t = cyc;
        sched_inta(t + 3);
        sched_cyc(t + 2 * P + 8, 1'b0, 1'b0, 8'h20);
        busy_until = t + 2 * P + 9 + P;
        int_in = 1'b1;
        tick(); tick();
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h20;
        tick();
        int_in = 1'b0;
        while (cyc < t + 2 * P + 7) tick();
        tick();
        cmd_valid = 1'b0;
        idle_to();
        check("conflict_nwr", wq.size(), 1);
        if (wq.size() > 0) check("conflict_wr", wq[0], {1'b0, 8'h20});

        for (int i = 0; i < 80; i++) begin
            int r;
            repeat ($urandom_range(0, 3)) tick();
            r = $urandom_range(0, 9);
            if (r < 4)      do_cmd(1'b0, 1'($urandom), 8'($urandom));
            else if (r < 8) do_cmd(1'b1, 1'($urandom), 8'h00);
            else            do_int($urandom_range(1, 2 * P + 5));
        end

        // Reset during a write strobe.
        c = cyc;
        sched_cyc(c + 1, 1'b0, 1'b1, 8'h5A);
        busy_until = c + P + 2;
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'h5A;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("wr_low_before_reset", wr_n, 0);
        #2;
        reset_n = 1'b0;
        exp_tl.delete();
        done_from = BIG;
        busy_until = -1;
        #1;
        check("async_reset_pins", {wr_n, cs_n, d_oe, busy, init_done}, 5'b11000);
        repeat (2) tick();
        reset_n = 1'b1;
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h33;
        repeat (5) tick();
        cmd_valid = 1'b0;
        do_init();
        idle_to();
        check("reinit_done", init_done, 1);
        do_cmd(1'b0, 1'b0, 8'h44);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
